// File: rtl/divided_clk_monitor_pkg.sv
// div_clk_mon_pkg: shared state type, default parameters and sizing helper for divided_clk_monitor
package div_clk_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  localparam int DEF_DIV_VALUE = 4;
  localparam int DEF_TOL = 0;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_CNT_W = 16;
  function automatic int match_cnt_w(input int lock_count);
    return $clog2(lock_count + 1);
  endfunction
endpackage

// File: rtl/divided_clk_monitor_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with asynchronous reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/divided_clk_monitor.sv
// divided_clk_monitor: edge strobes, half-period measurement and lock detection for a divided clock
module divided_clk_monitor
  import div_clk_mon_pkg::*;
#(
  parameter int DIV_VALUE = DEF_DIV_VALUE,
  parameter int TOL = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             half_period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);
  localparam int MCW = match_cnt_w(LOCK_COUNT);
  // lower bound clamped at 0 so a tolerance wider than the divide value cannot wrap
  localparam int LO = DIV_VALUE > TOL ? DIV_VALUE - TOL : 0;
  localparam logic [CNT_W:0] MIN_X = (CNT_W+1)'(LO);
  localparam logic [CNT_W:0] MAX_X = (CNT_W+1)'(DIV_VALUE + TOL);
  logic s2, prev, e, have_ref, match;
  logic [CNT_W-1:0] cnt;
  logic [MCW-1:0] match_cnt;
  state_t state;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(div_clk_in), .q(s2));
  assign e = s2 ^ prev;
  assign match = {1'b0, cnt} >= MIN_X && {1'b0, cnt} <= MAX_X;
  assign locked = state == LOCKED;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= 1'b0;
      cnt <= '0;
      have_ref <= 1'b0;
      match_cnt <= '0;
      state <= IDLE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      half_period <= '0;
      half_period_valid <= 1'b0;
      mismatch <= 1'b0;
      timeout <= 1'b0;
    end else begin
      prev <= s2;
      cnt <= e ? CNT_W'(1) : cnt + CNT_W'(!(&cnt));
      rise_pulse <= e & s2;
      fall_pulse <= e & ~s2;
      half_period_valid <= e & have_ref;
      mismatch <= 1'b0;
      timeout <= 1'b0;
      if (e) begin
        half_period <= cnt;
        have_ref <= 1'b1;
        if (state == IDLE) begin
          state <= ACQUIRE;
          match_cnt <= '0;
        end else if (have_ref && !match) begin
          state <= ACQUIRE;
          match_cnt <= '0;
          mismatch <= 1'b1;
        end else if (have_ref && state == ACQUIRE) begin
          match_cnt <= match_cnt + 1'b1;
          if (match_cnt == MCW'(LOCK_COUNT - 1)) state <= LOCKED;
        end
      end else if (state != IDLE && cnt == CNT_W'(TIMEOUT_CYCLES)) begin
        state <= IDLE;
        have_ref <= 1'b0;
        timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_divided_clk_monitor.sv
// tb_divided_clk_monitor: directed divider patterns with a per-DUT scoreboard of expected strobes
module tb_divided_clk_monitor;
  typedef struct {
    bit is_to;
    bit rise;
    bit hpv;
    int hp;
    bit mm;
    bit lk;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, div = 1'b0;
  logic rp[2], fp[2], hpv[2], lk[2], mm[2], to[2];
  logic [15:0] hp[2];
  exp_t q[2][$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  // u0: defaults; u1: wider tolerance and short timeout
  divided_clk_monitor u0 (
    .clk(clk), .rst(rst), .div_clk_in(div), .rise_pulse(rp[0]), .fall_pulse(fp[0]),
    .half_period(hp[0]), .half_period_valid(hpv[0]), .locked(lk[0]), .mismatch(mm[0]), .timeout(to[0])
  );
  divided_clk_monitor #(.TOL(1), .TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .div_clk_in(div), .rise_pulse(rp[1]), .fall_pulse(fp[1]),
    .half_period(hp[1]), .half_period_valid(hpv[1]), .locked(lk[1]), .mismatch(mm[1]), .timeout(to[1])
  );
  task automatic chk(string nm, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask
  task automatic chk_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_u%0d_rise", tag, i), int'(rp[i]), 0);
      chk($sformatf("%s_u%0d_fall", tag, i), int'(fp[i]), 0);
      chk($sformatf("%s_u%0d_hp", tag, i), int'(hp[i]), 0);
      chk($sformatf("%s_u%0d_hpv", tag, i), int'(hpv[i]), 0);
      chk($sformatf("%s_u%0d_locked", tag, i), int'(lk[i]), 0);
      chk($sformatf("%s_u%0d_mismatch", tag, i), int'(mm[i]), 0);
      chk($sformatf("%s_u%0d_timeout", tag, i), int'(to[i]), 0);
    end
  endtask
  task automatic push_edge(int u, bit refe, int d, bit mmx, bit lkx);
    exp_t e;
    e.is_to = 0; e.rise = ~div; e.hpv = !refe; e.hp = d; e.mm = mmx; e.lk = lkx;
    q[u].push_back(e);
  endtask
  task automatic tgl(int d);
    repeat (d) @(posedge clk);
    #1 div = ~div;
  endtask
  // per DUT: r = first edge is a reference, m = non-reference edges mismatch, l = edge index where locked is high (0 always, 99 never)
  task automatic phase(int d, int n, bit r0, bit m0, int l0, bit r1, bit m1, int l1);
    for (int i = 1; i <= n; i++) begin
      push_edge(0, r0 && i == 1, d, m0 && !(r0 && i == 1), i >= l0);
      push_edge(1, r1 && i == 1, d, m1 && !(r1 && i == 1), i >= l1);
      tgl(d);
    end
  endtask
  task automatic freeze(int cyc);
    exp_t e;
    e.is_to = 1; e.rise = 0; e.hpv = 0; e.hp = 0; e.mm = 0; e.lk = 0;
    q[0].push_back(e);
    q[1].push_back(e);
    repeat (cyc) @(posedge clk);
  endtask
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 2; i++)
        if (rp[i] | fp[i] | to[i]) begin
          if (q[i].size() == 0) chk($sformatf("u%0d_unexpected_event", i), 1, 0);
          else begin
            exp_t e;
            e = q[i].pop_front();
            chk($sformatf("u%0d_timeout", i), int'(to[i]), int'(e.is_to));
            chk($sformatf("u%0d_locked", i), int'(lk[i]), int'(e.lk));
            chk($sformatf("u%0d_mismatch", i), int'(mm[i]), int'(e.mm));
            chk($sformatf("u%0d_hpv", i), int'(hpv[i]), int'(e.hpv));
            if (!e.is_to) begin
              chk($sformatf("u%0d_rise", i), int'(rp[i]), int'(e.rise));
              chk($sformatf("u%0d_fall", i), int'(fp[i]), int'(!e.rise));
            end
            if (e.hpv) chk($sformatf("u%0d_half_period", i), int'(hp[i]), e.hp);
          end
        end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_zero("reset");
    fork
      phase(4, 9, 1, 0, 5, 1, 0, 5);
      begin
        repeat (6) @(posedge clk);
        #1 chk("latency_before", int'(rp[0]), 0);
        @(posedge clk);
        #1 chk("latency_at", int'(rp[0]), 1);
      end
    join
    freeze(80);
    chk("frozen_u0_locked", int'(lk[0]), 0);
    chk("frozen_u1_locked", int'(lk[1]), 0);
    phase(5, 8, 1, 1, 99, 1, 0, 5);
    phase(4, 5, 0, 0, 4, 0, 0, 0);
    phase(7, 1, 0, 1, 99, 0, 1, 99);
    phase(4, 5, 0, 0, 4, 0, 0, 4);
    phase(8, 4, 0, 1, 99, 0, 1, 99);
    phase(4, 5, 0, 0, 4, 0, 0, 4);
    freeze(80);
    phase(4, 5, 1, 0, 5, 1, 0, 5);
    repeat (4) @(posedge clk);
    #3 rst = 1;
    div = 0;
    q[0].delete();
    q[1].delete();
    #1 chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    phase(4, 2, 1, 0, 99, 1, 0, 99);
    freeze(80);
    chk("final_u0_queue", q[0].size(), 0);
    chk("final_u1_queue", q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
